// File: rtl/serial_uart_endpoint.sv
// serial_uart_endpoint
//
// Sits between the processor's serial MMIO buffer and the FPGA UART pins.
// Bytes the processor writes are queued in a TX FIFO and sent as 8N1 frames.
// Frames arriving on the RX line are decoded into an RX FIFO. The processor
// reads that FIFO through a show-ahead head port.
//
// Ports:
//   clock            system clock, all logic on the rising edge
//   reset            synchronous active-low reset (0 = reset)
//   proc_data_in     byte to transmit (processor serial_out)
//   proc_wren_in     push proc_data_in into the TX FIFO
//   proc_rden_in     pop the RX FIFO head
//   proc_data_out    RX FIFO head, 8'h00 when empty
//   proc_valid_out   RX FIFO not empty
//   proc_ready_out   TX FIFO not full
//   uart_rx_in       asynchronous UART receive line
//   uart_tx_out      UART transmit line, idles high
//   rx_overrun_out   sticky: received byte dropped, RX FIFO full
//   framing_err_out  sticky: stop bit sampled as 0
module serial_uart_endpoint #(
    parameter int CLKS_PER_BIT = 434,
    parameter int FIFO_AW      = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] proc_data_in,
    input  logic       proc_wren_in,
    input  logic       proc_rden_in,
    output logic [7:0] proc_data_out,
    output logic       proc_valid_out,
    output logic       proc_ready_out,
    input  logic       uart_rx_in,
    output logic       uart_tx_out,
    output logic       rx_overrun_out,
    output logic       framing_err_out
);

    localparam int DEPTH = 1 << FIFO_AW;
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0]   BIT_LAST   = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0]   HALF_LAST  = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0]   CNT_ONE    = CNT_W'(1);
    localparam logic [FIFO_AW:0]   FULL_COUNT = (FIFO_AW + 1)'(DEPTH);
    localparam logic [FIFO_AW:0]   PTR_ONE    = (FIFO_AW + 1)'(1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_t;

    uart_state_t      tx_state;
    logic [CNT_W-1:0] tx_cnt;
    logic [2:0]       tx_bit_idx;
    logic [7:0]       tx_shift;
    logic [7:0]       tx_mem [DEPTH];
    logic [FIFO_AW:0] tx_wr_ptr, tx_rd_ptr, tx_count;
    logic             tx_full, tx_empty, tx_push, tx_pop;

    uart_state_t      rx_state;
    logic [CNT_W-1:0] rx_cnt;
    logic [2:0]       rx_bit_idx;
    logic [7:0]       rx_shift;
    logic [7:0]       rx_mem [DEPTH];
    logic [FIFO_AW:0] rx_wr_ptr, rx_rd_ptr, rx_count;
    logic             rx_full, rx_empty, rx_push, rx_pop;
    logic             rx_meta, rx_sync;
    logic             rx_stop_sample;

    // TX FIFO status. The FSM pops in IDLE, and a write is accepted when
    // there is room or when that pop frees a slot on the same edge.
    assign tx_count       = tx_wr_ptr - tx_rd_ptr;
    assign tx_empty       = (tx_count == '0);
    assign tx_full        = (tx_count == FULL_COUNT);
    assign tx_pop         = (tx_state == IDLE) && !tx_empty;
    assign tx_push        = proc_wren_in && (!tx_full || tx_pop);
    assign proc_ready_out = !tx_full;

    // RX FIFO status. The head is show-ahead and reads zero when empty.
    // A byte is pushed at the mid-stop sample only when the stop bit is good
    // and there is room, counting a pop on the same edge as room.
    assign rx_count       = rx_wr_ptr - rx_rd_ptr;
    assign rx_empty       = (rx_count == '0);
    assign rx_full        = (rx_count == FULL_COUNT);
    assign rx_pop         = proc_rden_in && !rx_empty;
    assign rx_stop_sample = (rx_state == STOP) && (rx_cnt == BIT_LAST);
    assign rx_push        = rx_stop_sample && rx_sync && (!rx_full || rx_pop);
    assign proc_valid_out = !rx_empty;
    assign proc_data_out  = rx_empty ? 8'h00 : rx_mem[rx_rd_ptr[FIFO_AW-1:0]];

    // FIFO storage carries no reset. Emptiness comes from the pointers alone.
    always_ff @(posedge clock) begin
        if (tx_push)
            tx_mem[tx_wr_ptr[FIFO_AW-1:0]] <= proc_data_in;
        if (rx_push)
            rx_mem[rx_wr_ptr[FIFO_AW-1:0]] <= rx_shift;
    end

    // FIFO pointers. The pointers are one bit wider than the address so that
    // full and empty can be told apart from the pointer difference.
    always_ff @(posedge clock) begin
        if (!reset) begin
            tx_wr_ptr <= '0;
            tx_rd_ptr <= '0;
            rx_wr_ptr <= '0;
            rx_rd_ptr <= '0;
        end else begin
            if (tx_push) tx_wr_ptr <= tx_wr_ptr + PTR_ONE;
            if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + PTR_ONE;
            if (rx_push) rx_wr_ptr <= rx_wr_ptr + PTR_ONE;
            if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + PTR_ONE;
        end
    end

    // TX state machine. uart_tx_out is registered from the current state.
    // The line therefore lags the state by one cycle. This gives the
    // two-cycle write-to-start latency, and every bit still lasts exactly
    // CLKS_PER_BIT cycles.
    always_ff @(posedge clock) begin
        if (!reset) begin
            tx_state    <= IDLE;
            tx_cnt      <= '0;
            tx_bit_idx  <= '0;
            tx_shift    <= '0;
            uart_tx_out <= 1'b1;
        end else begin
            uart_tx_out <= (tx_state == START) ? 1'b0 :
                           (tx_state == DATA)  ? tx_shift[0] : 1'b1;
            case (tx_state)
                IDLE: begin
                    tx_cnt <= '0;
                    if (tx_pop) begin
                        tx_shift <= tx_mem[tx_rd_ptr[FIFO_AW-1:0]];
                        tx_state <= START;
                    end
                end
                START: begin
                    if (tx_cnt == BIT_LAST) begin
                        tx_cnt     <= '0;
                        tx_bit_idx <= '0;
                        tx_state   <= DATA;
                    end else begin
                        tx_cnt <= tx_cnt + CNT_ONE;
                    end
                end
                DATA: begin
                    if (tx_cnt == BIT_LAST) begin
                        tx_cnt   <= '0;
                        tx_shift <= {1'b0, tx_shift[7:1]};
                        if (tx_bit_idx == 3'd7)
                            tx_state <= STOP;
                        else
                            tx_bit_idx <= tx_bit_idx + 3'd1;
                    end else begin
                        tx_cnt <= tx_cnt + CNT_ONE;
                    end
                end
                STOP: begin
                    if (tx_cnt == BIT_LAST) begin
                        tx_cnt   <= '0;
                        tx_state <= IDLE;
                    end else begin
                        tx_cnt <= tx_cnt + CNT_ONE;
                    end
                end
                default: tx_state <= IDLE;
            endcase
        end
    end

    // Two-flop synchroniser for the asynchronous RX line. It presets to
    // idle-high so that reset does not look like a start bit.
    always_ff @(posedge clock) begin
        if (!reset) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= uart_rx_in;
            rx_sync <= rx_meta;
        end
    end

    // RX state machine. The start bit is confirmed at its midpoint. After
    // that, every sample lands mid-bit. STOP returns to IDLE right at the
    // mid-stop sample, so a start bit that follows straight away is not missed.
    always_ff @(posedge clock) begin
        if (!reset) begin
            rx_state        <= IDLE;
            rx_cnt          <= '0;
            rx_bit_idx      <= '0;
            rx_shift        <= '0;
            rx_overrun_out  <= 1'b0;
            framing_err_out <= 1'b0;
        end else begin
            case (rx_state)
                IDLE: begin
                    rx_cnt <= '0;
                    if (!rx_sync)
                        rx_state <= START;
                end
                START: begin
                    if (rx_cnt == HALF_LAST) begin
                        rx_cnt     <= '0;
                        rx_bit_idx <= '0;
                        rx_state   <= rx_sync ? IDLE : DATA;
                    end else begin
                        rx_cnt <= rx_cnt + CNT_ONE;
                    end
                end
                DATA: begin
                    if (rx_cnt == BIT_LAST) begin
                        rx_cnt   <= '0;
                        rx_shift <= {rx_sync, rx_shift[7:1]};
                        if (rx_bit_idx == 3'd7)
                            rx_state <= STOP;
                        else
                            rx_bit_idx <= rx_bit_idx + 3'd1;
                    end else begin
                        rx_cnt <= rx_cnt + CNT_ONE;
                    end
                end
                STOP: begin
                    if (rx_cnt == BIT_LAST) begin
                        rx_cnt   <= '0;
                        rx_state <= IDLE;
                        if (!rx_sync)
                            framing_err_out <= 1'b1;
                        else if (rx_full && !rx_pop)
                            rx_overrun_out <= 1'b1;
                    end else begin
                        rx_cnt <= rx_cnt + CNT_ONE;
                    end
                end
                default: rx_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_uart_endpoint.sv
// tb_serial_uart_endpoint
//
// Directed and randomized bench for serial_uart_endpoint at CLKS_PER_BIT=8.
// Expected TX waveforms and received bytes come from the 8N1 frame rules and
// from queue models of the two FIFOs.
module tb_serial_uart_endpoint;

    localparam int CPB = 8;

    logic       clock = 1'b0;
    logic       reset;
    logic [7:0] proc_data_in;
    logic       proc_wren_in;
    logic       proc_rden_in;
    logic [7:0] proc_data_out;
    logic       proc_valid_out;
    logic       proc_ready_out;
    logic       uart_rx_in;
    logic       uart_tx_out;
    logic       rx_overrun_out;
    logic       framing_err_out;

    int total = 0;
    int bad   = 0;

    logic [7:0] tx_exp [$];
    logic [7:0] rx_exp [$];

    serial_uart_endpoint #(
        .CLKS_PER_BIT (CPB),
        .FIFO_AW      (4)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .proc_data_in    (proc_data_in),
        .proc_wren_in    (proc_wren_in),
        .proc_rden_in    (proc_rden_in),
        .proc_data_out   (proc_data_out),
        .proc_valid_out  (proc_valid_out),
        .proc_ready_out  (proc_ready_out),
        .uart_rx_in      (uart_rx_in),
        .uart_tx_out     (uart_tx_out),
        .rx_overrun_out  (rx_overrun_out),
        .framing_err_out (framing_err_out)
    );

    // Free-running clock with a 10-unit period
    always #5 clock = ~clock;

    // Hard stop if something hangs
    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "[TB] watchdog");
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // One processor-side cycle. The inputs are held through one rising edge.
    task automatic applyStimulus(input logic wren, input logic rden, input logic [7:0] data);
        proc_wren_in = wren;
        proc_rden_in = rden;
        proc_data_in = data;
        tick();
        proc_wren_in = 1'b0;
        proc_rden_in = 1'b0;
    endtask

    // Drive a complete 8N1 frame onto the RX line, then return it to idle
    task automatic sendFrame(input logic [7:0] b, input logic stop_bit);
        uart_rx_in = 1'b0;
        ticks(CPB);
        for (int i = 0; i < 8; i++) begin
            uart_rx_in = b[i];
            ticks(CPB);
        end
        uart_rx_in = stop_bit;
        ticks(CPB);
        uart_rx_in = 1'b1;
    endtask

    // Wait for a start bit on TX, then decode one byte at mid-bit.
    // Returns at mid-stop.
    task automatic captureTx(output logic [7:0] b);
        int waited = 0;
        b = 8'h00;
        while (uart_tx_out !== 1'b0 && waited < 400) begin
            tick();
            waited++;
        end
        checkOutput("tx_start_seen", {31'd0, uart_tx_out}, 32'd0);
        ticks(CPB / 2);
        checkOutput("tx_mid_start", {31'd0, uart_tx_out}, 32'd0);
        for (int i = 0; i < 8; i++) begin
            ticks(CPB);
            b[i] = uart_tx_out;
        end
        ticks(CPB);
        checkOutput("tx_stop_bit", {31'd0, uart_tx_out}, 32'd1);
    endtask

    initial begin
        logic [7:0] b;
        logic [7:0] got;
        logic       exp_bit;
        logic       ovr_model;

        reset        = 1'b0;
        proc_data_in = 8'h00;
        proc_wren_in = 1'b0;
        proc_rden_in = 1'b0;
        uart_rx_in   = 1'b1;
        ticks(3);

        // Reset state
        checkOutput("rst_tx",      {31'd0, uart_tx_out},     32'd1);
        checkOutput("rst_valid",   {31'd0, proc_valid_out},  32'd0);
        checkOutput("rst_ready",   {31'd0, proc_ready_out},  32'd1);
        checkOutput("rst_data",    {24'd0, proc_data_out},   32'h00);
        checkOutput("rst_overrun", {31'd0, rx_overrun_out},  32'd0);
        checkOutput("rst_framing", {31'd0, framing_err_out}, 32'd0);
        reset = 1'b1;
        tick();

        // Single write of A5: start bit at T+2, then the frame bit by bit
        applyStimulus(1'b1, 1'b0, 8'hA5);
        checkOutput("tx_idle_t0", {31'd0, uart_tx_out}, 32'd1);
        tick();
        checkOutput("tx_idle_t1", {31'd0, uart_tx_out}, 32'd1);
        tick();
        for (int k = 0; k < 10 * CPB; k++) begin
            if (k < CPB)
                exp_bit = 1'b0;
            else if (k < 9 * CPB)
                exp_bit = (8'hA5 >> ((k - CPB) / CPB)) & 8'h01;
            else
                exp_bit = 1'b1;
            checkOutput("tx_wave", {31'd0, uart_tx_out}, {31'd0, exp_bit});
            if (k % CPB == 0)
                checkOutput("tx_ready", {31'd0, proc_ready_out}, 32'd1);
            tick();
        end
        checkOutput("tx_idle_after", {31'd0, uart_tx_out}, 32'd1);

        // RX frame 3C: valid rises 3 cycles after the mid-stop point
        uart_rx_in = 1'b0;
        ticks(CPB);
        for (int i = 0; i < 8; i++) begin
            uart_rx_in = ((8'h3C >> i) & 8'h01) != 0;
            ticks(CPB);
        end
        uart_rx_in = 1'b1;
        ticks(CPB / 2 + 2);
        checkOutput("rx_valid_early", {31'd0, proc_valid_out}, 32'd0);
        tick();
        checkOutput("rx_valid_rise", {31'd0, proc_valid_out}, 32'd1);
        checkOutput("rx_data_3c", {24'd0, proc_data_out}, 32'h3C);
        ticks(3);
        applyStimulus(1'b0, 1'b1, 8'h00);
        checkOutput("rx_pop_valid", {31'd0, proc_valid_out}, 32'd0);
        checkOutput("rx_pop_data", {24'd0, proc_data_out}, 32'h00);

        // Two-cycle low glitch: ignored, no flags
        uart_rx_in = 1'b0;
        ticks(2);
        uart_rx_in = 1'b1;
        ticks(3 * CPB);
        checkOutput("glitch_valid",   {31'd0, proc_valid_out},  32'd0);
        checkOutput("glitch_overrun", {31'd0, rx_overrun_out},  32'd0);
        checkOutput("glitch_framing", {31'd0, framing_err_out}, 32'd0);
        b = 8'($urandom_range(0, 255));
        sendFrame(b, 1'b1);
        ticks(4);
        checkOutput("post_glitch_data", {24'd0, proc_data_out}, {24'd0, b});
        applyStimulus(1'b0, 1'b1, 8'h00);

        // TX burst of 17 random bytes in consecutive cycles
        for (int i = 0; i < 17; i++)
            tx_exp.push_back(8'($urandom_range(0, 255)));
        fork
            begin
                for (int i = 0; i < 17; i++) begin
                    checkOutput("burst_ready", {31'd0, proc_ready_out}, 32'd1);
                    applyStimulus(1'b1, 1'b0, tx_exp[i]);
                end
                checkOutput("burst_full", {31'd0, proc_ready_out}, 32'd0);
            end
            begin
                logic [7:0] cap;
                for (int j = 0; j < 17; j++) begin
                    captureTx(cap);
                    checkOutput("burst_byte", {24'd0, cap}, {24'd0, tx_exp[j]});
                end
            end
        join
        ticks(2 * CPB);
        checkOutput("burst_drained", {31'd0, proc_ready_out}, 32'd1);

        // 17 RX frames with no reads: 16 kept, the 17th dropped with overrun
        ovr_model = 1'b0;
        for (int i = 0; i < 17; i++) begin
            b = 8'($urandom_range(0, 255));
            sendFrame(b, 1'b1);
            if (rx_exp.size() < 16)
                rx_exp.push_back(b);
            else
                ovr_model = 1'b1;
        end
        ticks(5);
        checkOutput("ovr_flag",  {31'd0, rx_overrun_out}, {31'd0, ovr_model});
        checkOutput("ovr_valid", {31'd0, proc_valid_out}, 32'd1);
        checkOutput("ovr_head",  {24'd0, proc_data_out},  {24'd0, rx_exp[0]});
        while (rx_exp.size() > 0) begin
            b = rx_exp.pop_front();
            checkOutput("rx_drain", {24'd0, proc_data_out}, {24'd0, b});
            applyStimulus(1'b0, 1'b1, 8'h00);
        end
        checkOutput("rx_drain_empty", {31'd0, proc_valid_out}, 32'd0);

        // Stop bit 0 sets the framing flag and pushes nothing
        sendFrame(8'($urandom_range(0, 255)), 1'b0);
        ticks(3 * CPB);
        checkOutput("frm_flag",  {31'd0, framing_err_out}, 32'd1);
        checkOutput("frm_valid", {31'd0, proc_valid_out},  32'd0);

        // Reset asserted mid-TX, in the data bits
        b = 8'($urandom_range(0, 255));
        sendFrame(b, 1'b1);
        ticks(4);
        checkOutput("pre_rst_valid", {31'd0, proc_valid_out}, 32'd1);
        applyStimulus(1'b1, 1'b0, 8'h00);
        applyStimulus(1'b1, 1'b0, 8'h00);
        ticks(2 * CPB + 5);
        reset = 1'b0;
        tick();
        checkOutput("midrst_tx",      {31'd0, uart_tx_out},     32'd1);
        checkOutput("midrst_valid",   {31'd0, proc_valid_out},  32'd0);
        checkOutput("midrst_ready",   {31'd0, proc_ready_out},  32'd1);
        checkOutput("midrst_data",    {24'd0, proc_data_out},   32'h00);
        checkOutput("midrst_overrun", {31'd0, rx_overrun_out},  32'd0);
        checkOutput("midrst_framing", {31'd0, framing_err_out}, 32'd0);
        reset = 1'b1;
        for (int i = 0; i < 6; i++) begin
            ticks(5);
            checkOutput("midrst_quiet", {31'd0, uart_tx_out}, 32'd1);
        end
        b = 8'($urandom_range(0, 255));
        applyStimulus(1'b1, 1'b0, b);
        captureTx(got);
        checkOutput("midrst_new_byte", {24'd0, got}, {24'd0, b});
        ticks(CPB);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
